uart_rx_fifo: RTL and testbench

//   Receive buffer directly downstream of uart_rx. Captures each byte uart_rx presents
//   (rx_data_valid/rx_data) and returns the finish pulse on rx_ctrl[1] to release it to IDLE.

---
 rtl/uart_rx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: acknowledges each held byte through rx_ctrl[1]
// and queues it in a first-word-fall-through FIFO for the CPU side.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  output logic [1:0]        rx_ctrl,
  input  logic              rx_en,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state;
  logic              finish;
  logic              guard;
  logic              ovr_seen;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              byte_seen;
  logic              push;
  logic              pop;
  logic              drop;
  logic              stall_hit;
  logic [ADDR_W:0]   cnt_nxt;

  function automatic logic [ADDR_W:0] next_count(input logic [ADDR_W:0] c,
                                                 input logic inc,
                                                 input logic dec);
    logic [ADDR_W:0] r;
    case ({inc, dec})
      2'b10:   r = c + 1'b1;
      2'b01:   r = c - 1'b1;
      default: r = c;
    endcase
    return r;
  endfunction

  always_comb begin
    byte_seen = 1'b0;
    push      = 1'b0;
    drop      = 1'b0;
    stall_hit = 1'b0;
    pop       = 1'b0;
    // guard keeps the cycle right after ACK deaf so finish shows a low phase
    byte_seen = (state == S_WAIT) && !guard && rx_data_valid;
    push      = byte_seen && !full;
    drop      = byte_seen && full && DROP_ON_FULL;
    stall_hit = byte_seen && full && !DROP_ON_FULL && !ovr_seen;
    pop       = rd_en && !empty;
    cnt_nxt   = next_count(count, push, pop);
  end

  // handshake with uart_rx
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_WAIT;
      finish   <= 1'b0;
      guard    <= 1'b0;
      ovr_seen <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      guard <= 1'b0;
      case (state)
        S_WAIT: begin
          if (push || drop) begin
            finish   <= 1'b1;
            ovr_seen <= 1'b0;
            state    <= S_ACK;
          end else if (stall_hit) begin
            ovr_seen <= 1'b1;
          end
        end
        S_ACK: begin
          if (!rx_data_valid) begin
            finish <= 1'b0;
            guard  <= 1'b1;
            state  <= S_WAIT;
          end
        end
        default: state <= S_WAIT;
      endcase
      if (drop || stall_hit)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == FULL_CNT);
    end
  end

  // storage, no reset
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rx_data;
  end

  assign rd_data = mem[rd_ptr];
  assign rx_ctrl = {finish, rx_en};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one stall-mode and one drop-mode instance driven by a
// uart_rx handshake model and checked against a queue-based FIFO model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst           [2];
  logic       rx_data_valid [2];
  logic [7:0] rx_data       [2];
  logic [1:0] rx_ctrl       [2];
  logic       rd_en         [2];
  logic [7:0] rd_data       [2];
  logic       empty         [2];
  logic       full          [2];
  logic [4:0] count         [2];
  logic       overrun       [2];
  logic       clr_overrun   [2];
  logic       rx_en;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];
  logic       movr [2];

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .DROP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .rst(rst[0]), .rx_data_valid(rx_data_valid[0]), .rx_data(rx_data[0]),
    .rx_ctrl(rx_ctrl[0]), .rx_en(rx_en), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
    .empty(empty[0]), .full(full[0]), .count(count[0]), .overrun(overrun[0]),
    .clr_overrun(clr_overrun[0])
  );

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .DROP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst(rst[1]), .rx_data_valid(rx_data_valid[1]), .rx_data(rx_data[1]),
    .rx_ctrl(rx_ctrl[1]), .rx_en(rx_en), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
    .empty(empty[1]), .full(full[1]), .count(count[1]), .overrun(overrun[1]),
    .clr_overrun(clr_overrun[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int msize(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [7:0] mfront(input int d);
    return (d == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic mpush(input int d, input logic [7:0] b);
    if (d == 0) mq0.push_back(b);
    else        mq1.push_back(b);
  endtask

  task automatic mpop(input int d);
    logic [7:0] b;
    if (d == 0) b = mq0.pop_front();
    else        b = mq1.pop_front();
  endtask

  task automatic mclear(input int d);
    if (d == 0) mq0.delete();
    else        mq1.delete();
    movr[d] = 1'b0;
  endtask

  task automatic check_state(input int d, input string tag);
    int n;
    n = msize(d);
    chk({tag, ":count"}, 32'(count[d]), 32'(n));
    chk({tag, ":empty"}, 32'(empty[d]), 32'(n == 0));
    chk({tag, ":full"}, 32'(full[d]), 32'(n == 16));
    chk({tag, ":overrun"}, 32'(overrun[d]), 32'(movr[d]));
    if (n > 0)
      chk({tag, ":rd_data"}, 32'(rd_data[d]), 32'(mfront(d)));
  endtask

  // Let uart_rx release the byte: drop valid two cycles after finish rises,
  // wait for finish to fall, then allow the one-cycle low phase.
  task automatic finish_handshake(input int d, input string tag);
    int w;
    @(negedge clk);
    @(negedge clk);
    rx_data_valid[d] = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (rx_ctrl[d][1] && w < 10);
    chk({tag, ":finish_low"}, 32'(rx_ctrl[d][1]), 32'd0);
    @(negedge clk);
  endtask

  // uart_rx presents a byte and waits (bounded) for the finish pulse
  task automatic push_byte(input int d, input logic [7:0] b, input string tag);
    int w;
    rx_data[d]       = b;
    rx_data_valid[d] = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rx_ctrl[d][1] && w < 50);
    chk({tag, ":ack_latency"}, 32'(w), 32'd1);
    if (msize(d) < 16) mpush(d, b);
    else               movr[d] = 1'b1;
    check_state(d, tag);
    finish_handshake(d, tag);
  endtask

  task automatic pop_one(input int d, input string tag);
    rd_en[d] = 1'b1;
    @(negedge clk);
    rd_en[d] = 1'b0;
    if (msize(d) > 0) mpop(d);
    check_state(d, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] b;
    int         op;
    for (int d = 0; d < 2; d++) begin
      rst[d]           = 1'b1;
      rx_data_valid[d] = 1'b0;
      rx_data[d]       = 8'h00;
      rd_en[d]         = 1'b0;
      clr_overrun[d]   = 1'b0;
      movr[d]          = 1'b0;
    end
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check_state(0, "reset0");
    check_state(1, "reset1");
    chk("reset:rx_ctrl", 32'(rx_ctrl[0]), 32'd0);
    rx_en = 1'b1;
    #1;
    chk("rx_en_pass", 32'(rx_ctrl[0]), 32'd1);
    @(negedge clk);

    // single byte
    push_byte(0, 8'hA5, "single");
    chk("single:rd_data", 32'(rd_data[0]), 32'hA5);
    pop_one(0, "single_pop");

    // fill to full
    for (int i = 0; i < 16; i++)
      push_byte(0, 8'(i), "fill");
    chk("fill:full", 32'(full[0]), 32'd1);
    chk("fill:count", 32'(count[0]), 32'd16);

    // stall mode: byte arrives while full
    rx_data[0]       = 8'h55;
    rx_data_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    movr[0] = 1'b1;
    chk("stall:finish", 32'(rx_ctrl[0][1]), 32'd0);
    check_state(0, "stall");
    clr_overrun[0] = 1'b1;
    @(negedge clk);
    clr_overrun[0] = 1'b0;
    movr[0] = 1'b0;
    @(negedge clk);
    check_state(0, "stall_once");
    rd_en[0] = 1'b1;
    @(negedge clk);
    rd_en[0] = 1'b0;
    mpop(0);
    chk("stall_pop:finish", 32'(rx_ctrl[0][1]), 32'd0);
    check_state(0, "stall_pop");
    @(negedge clk);
    mpush(0, 8'h55);
    chk("stall_push:finish", 32'(rx_ctrl[0][1]), 32'd1);
    check_state(0, "stall_push");
    finish_handshake(0, "stall_rel");
    check_state(0, "stall_rel");

    // drain in order, then wrap
    while (msize(0) > 0) pop_one(0, "drain");
    for (int i = 0; i < 4; i++) push_byte(0, 8'(8'h10 + i), "wrap");
    while (msize(0) > 0) pop_one(0, "wrap_pop");

    // push and pop in the same cycle
    for (int i = 0; i < 3; i++) push_byte(0, 8'($urandom_range(0, 255)), "pre3");
    b = 8'($urandom_range(0, 255));
    rx_data[0]       = b;
    rx_data_valid[0] = 1'b1;
    rd_en[0]         = 1'b1;
    @(negedge clk);
    rd_en[0] = 1'b0;
    mpop(0);
    mpush(0, b);
    chk("same_cycle:finish", 32'(rx_ctrl[0][1]), 32'd1);
    check_state(0, "same_cycle");
    finish_handshake(0, "same_cycle");
    while (msize(0) > 0) pop_one(0, "same_drain");
    pop_one(0, "pop_empty");
    pop_one(0, "pop_empty2");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      if (op <= 1 && msize(0) < 16) begin
        push_byte(0, 8'($urandom_range(0, 255)), "rnd_push");
      end else if (op == 3) begin
        clr_overrun[0] = 1'b1;
        @(negedge clk);
        clr_overrun[0] = 1'b0;
        movr[0] = 1'b0;
        check_state(0, "rnd_clr");
      end else begin
        pop_one(0, "rnd_pop");
      end
    end
    while (msize(0) > 0) pop_one(0, "rnd_drain");

    // drop mode: 17th byte acked and discarded
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h77) b = 8'h78;
      push_byte(1, b, "dfill");
    end
    push_byte(1, 8'h77, "drop");
    chk("drop:overrun", 32'(overrun[1]), 32'd1);
    chk("drop:count", 32'(count[1]), 32'd16);
    while (msize(1) > 0) begin
      chk("drop:not77", 32'(rd_data[1] == 8'h77), 32'd0);
      pop_one(1, "ddrain");
    end

    // reset while in ACK
    rx_data[1]       = 8'h3C;
    rx_data_valid[1] = 1'b1;
    @(negedge clk);
    chk("rst_ack:finish_up", 32'(rx_ctrl[1][1]), 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1]           = 1'b0;
    rx_data_valid[1] = 1'b0;
    mclear(1);
    chk("rst_ack:finish", 32'(rx_ctrl[1][1]), 32'd0);
    check_state(1, "rst_ack");
    @(negedge clk);
    chk("rst_ack2:finish", 32'(rx_ctrl[1][1]), 32'd0);
    check_state(1, "rst_ack2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
